// File: rtl/decode_scoreboard_pkg.sv
// Shared types and sizing for the decode-stage register scoreboard.
// Completion ports arrive packed; helpers split them per port.
package decode_scoreboard_pkg;

  localparam int NUM_REGS     = 32;
  localparam int REG_W        = 5;
  localparam int ROB_IDX_W    = 4;
  localparam int NUM_WB       = 2;
  localparam int MAX_INFLIGHT = 8;
  localparam int CNT_W        = $clog2(NUM_REGS + 1);

  typedef struct packed {
    logic                 busy;
    logic [ROB_IDX_W-1:0] tag;
  } sb_entry_t;

  typedef logic [NUM_WB-1:0][REG_W-1:0]     wb_rd_t;
  typedef logic [NUM_WB-1:0][ROB_IDX_W-1:0] wb_tag_t;

  function automatic wb_rd_t unpack_rd(
    input logic [NUM_WB*REG_W-1:0] v
  );
    wb_rd_t r;
    for (int w = 0; w < NUM_WB; w++)
      r[w] = v[w*REG_W +: REG_W];
    return r;
  endfunction

  function automatic wb_tag_t unpack_tag(
    input logic [NUM_WB*ROB_IDX_W-1:0] v
  );
    wb_tag_t t;
    for (int w = 0; w < NUM_WB; w++)
      t[w] = v[w*ROB_IDX_W +: ROB_IDX_W];
    return t;
  endfunction

endpackage

// File: rtl/decode_scoreboard_lookup.sv
// Combinational source-operand read port with same-cycle
// completion bypass.
module scoreboard_lookup
  import decode_scoreboard_pkg::*;
(
  input  logic [REG_W-1:0]            rs,
  input  logic                        used,
  input  logic                        busy,
  input  logic [ROB_IDX_W-1:0]        tag,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*REG_W-1:0]     wb_rd,
  input  logic [NUM_WB*ROB_IDX_W-1:0] wb_rob_idx,
  output logic                        pending,
  output logic [ROB_IDX_W-1:0]        pending_tag
);

  wb_rd_t  rd_u;
  wb_tag_t tag_u;
  logic    bypass;

  assign rd_u  = unpack_rd(wb_rd);
  assign tag_u = unpack_tag(wb_rob_idx);

  // A matching completion this cycle is forwarded, so no wait.
  always_comb begin
    bypass = 1'b0;
    for (int w = 0; w < NUM_WB; w++)
      if (wb_valid[w] && rd_u[w] == rs && tag_u[w] == tag)
        bypass = 1'b1;
  end

  assign pending = used && (rs != '0) && busy && !bypass;
  assign pending_tag = pending ? tag : '0;

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight long-latency
// producers per register and stalls decode on RAW hazards.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_issue_valid,
  input  logic                        in_issue_long_lat,
  input  logic [REG_W-1:0]            in_issue_rd,
  input  logic [ROB_IDX_W-1:0]        in_issue_rob_idx,
  input  logic [REG_W-1:0]            in_rs1,
  input  logic [REG_W-1:0]            in_rs2,
  input  logic                        in_rs1_used,
  input  logic                        in_rs2_used,
  input  logic [NUM_WB-1:0]           in_wb_valid,
  input  logic [NUM_WB*REG_W-1:0]     in_wb_rd,
  input  logic [NUM_WB*ROB_IDX_W-1:0] in_wb_rob_idx,
  input  logic                        in_flush,
  output logic                        out_stall,
  output logic                        out_pc_write_disable,
  output logic                        out_IFID_write_disable,
  output logic                        out_control_src,
  output logic                        out_rs1_pending,
  output logic                        out_rs2_pending,
  output logic [ROB_IDX_W-1:0]        out_rs1_tag,
  output logic [ROB_IDX_W-1:0]        out_rs2_tag,
  output logic [CNT_W-1:0]            out_busy_count
);

  sb_entry_t        ent_q [NUM_REGS];
  sb_entry_t        ent_d [NUM_REGS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  wb_rd_t           rd_u;
  wb_tag_t          tag_u;
  logic             full_block;
  logic             issue_fire;

  assign rd_u  = unpack_rd(in_wb_rd);
  assign tag_u = unpack_tag(in_wb_rob_idx);

  scoreboard_lookup u_rs1 (
    .rs          (in_rs1),
    .used        (in_rs1_used),
    .busy        (ent_q[in_rs1].busy),
    .tag         (ent_q[in_rs1].tag),
    .wb_valid    (in_wb_valid),
    .wb_rd       (in_wb_rd),
    .wb_rob_idx  (in_wb_rob_idx),
    .pending     (out_rs1_pending),
    .pending_tag (out_rs1_tag)
  );

  scoreboard_lookup u_rs2 (
    .rs          (in_rs2),
    .used        (in_rs2_used),
    .busy        (ent_q[in_rs2].busy),
    .tag         (ent_q[in_rs2].tag),
    .wb_valid    (in_wb_valid),
    .wb_rd       (in_wb_rd),
    .wb_rob_idx  (in_wb_rob_idx),
    .pending     (out_rs2_pending),
    .pending_tag (out_rs2_tag)
  );

  // Re-targeting an already busy rd needs no new slot.
  assign full_block = in_issue_long_lat
                   && (in_issue_rd != '0)
                   && (cnt_q == CNT_W'(MAX_INFLIGHT))
                   && !ent_q[in_issue_rd].busy;

  assign out_stall = in_issue_valid && !in_flush
                  && (out_rs1_pending || out_rs2_pending
                      || full_block);

  assign out_pc_write_disable   = out_stall;
  assign out_IFID_write_disable = out_stall;
  assign out_control_src        = !out_stall;
  assign out_busy_count         = cnt_q;

  assign issue_fire = in_issue_valid && in_issue_long_lat
                   && (in_issue_rd != '0)
                   && !out_stall && !in_flush;

  // Priority: flush > issue > completion.
  always_comb begin
    ent_d = ent_q;
    for (int r = 0; r < NUM_REGS; r++)
      for (int w = 0; w < NUM_WB; w++)
        if (in_wb_valid[w] && rd_u[w] == REG_W'(r)
            && ent_q[r].busy && tag_u[w] == ent_q[r].tag)
          ent_d[r].busy = 1'b0;
    if (issue_fire) begin
      ent_d[in_issue_rd].busy = 1'b1;
      ent_d[in_issue_rd].tag  = in_issue_rob_idx;
    end
    if (in_flush)
      for (int r = 0; r < NUM_REGS; r++)
        ent_d[r].busy = 1'b0;
    ent_d[0] = '0;
    cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      cnt_d = cnt_d + CNT_W'(ent_d[r].busy);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        ent_q[r] <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: stimulus pushes expected
// lookup/stall/count values, a negedge monitor pops and compares.
module tb_decode_scoreboard;
  import decode_scoreboard_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        in_issue_valid;
  logic                        in_issue_long_lat;
  logic [REG_W-1:0]            in_issue_rd;
  logic [ROB_IDX_W-1:0]        in_issue_rob_idx;
  logic [REG_W-1:0]            in_rs1;
  logic [REG_W-1:0]            in_rs2;
  logic                        in_rs1_used;
  logic                        in_rs2_used;
  logic [NUM_WB-1:0]           in_wb_valid;
  logic [NUM_WB*REG_W-1:0]     in_wb_rd;
  logic [NUM_WB*ROB_IDX_W-1:0] in_wb_rob_idx;
  logic                        in_flush;
  logic                        out_stall;
  logic                        out_pc_write_disable;
  logic                        out_IFID_write_disable;
  logic                        out_control_src;
  logic                        out_rs1_pending;
  logic                        out_rs2_pending;
  logic [ROB_IDX_W-1:0]        out_rs1_tag;
  logic [ROB_IDX_W-1:0]        out_rs2_tag;
  logic [CNT_W-1:0]            out_busy_count;

  decode_scoreboard dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_issue_valid         (in_issue_valid),
    .in_issue_long_lat      (in_issue_long_lat),
    .in_issue_rd            (in_issue_rd),
    .in_issue_rob_idx       (in_issue_rob_idx),
    .in_rs1                 (in_rs1),
    .in_rs2                 (in_rs2),
    .in_rs1_used            (in_rs1_used),
    .in_rs2_used            (in_rs2_used),
    .in_wb_valid            (in_wb_valid),
    .in_wb_rd               (in_wb_rd),
    .in_wb_rob_idx          (in_wb_rob_idx),
    .in_flush               (in_flush),
    .out_stall              (out_stall),
    .out_pc_write_disable   (out_pc_write_disable),
    .out_IFID_write_disable (out_IFID_write_disable),
    .out_control_src        (out_control_src),
    .out_rs1_pending        (out_rs1_pending),
    .out_rs2_pending        (out_rs2_pending),
    .out_rs1_tag            (out_rs1_tag),
    .out_rs2_tag            (out_rs2_tag),
    .out_busy_count         (out_busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         st;
    bit         p1;
    logic [3:0] t1;
    bit         p2;
    logic [3:0] t2;
    logic [5:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic idle();
    in_issue_valid    = 1'b0;
    in_issue_long_lat = 1'b0;
    in_issue_rd       = '0;
    in_issue_rob_idx  = '0;
    in_rs1            = '0;
    in_rs2            = '0;
    in_rs1_used       = 1'b0;
    in_rs2_used       = 1'b0;
    in_wb_valid       = '0;
    in_wb_rd          = '0;
    in_wb_rob_idx     = '0;
    in_flush          = 1'b0;
  endtask

  task automatic issue(input int rd, input int tag,
                       input bit ll);
    in_issue_valid    = 1'b1;
    in_issue_long_lat = ll;
    in_issue_rd       = REG_W'(rd);
    in_issue_rob_idx  = ROB_IDX_W'(tag);
  endtask

  task automatic rs1(input int r);
    in_rs1      = REG_W'(r);
    in_rs1_used = 1'b1;
  endtask

  task automatic rs2(input int r);
    in_rs2      = REG_W'(r);
    in_rs2_used = 1'b1;
  endtask

  task automatic wb(input int port, input int rd,
                    input int tag);
    in_wb_valid[port] = 1'b1;
    in_wb_rd[port*REG_W +: REG_W] = REG_W'(rd);
    in_wb_rob_idx[port*ROB_IDX_W +: ROB_IDX_W]
      = ROB_IDX_W'(tag);
  endtask

  task automatic expect_(input string n, input bit st,
                         input bit p1, input int t1,
                         input bit p2, input int t2,
                         input int cnt);
    exp_t e;
    e.name = n;
    e.st   = st;
    e.p1   = p1;
    e.t1   = 4'(t1);
    e.p2   = p2;
    e.t2   = 4'(t2);
    e.cnt  = 6'(cnt);
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (out_stall !== e.st
          || out_pc_write_disable !== e.st
          || out_IFID_write_disable !== e.st
          || out_control_src !== !e.st
          || out_rs1_pending !== e.p1
          || out_rs1_tag !== e.t1
          || out_rs2_pending !== e.p2
          || out_rs2_tag !== e.t2
          || out_busy_count !== e.cnt) begin
        errors++;
        $display({"FAIL %s: got st=%b pcwd=%b ifid=%b ctl=%b ",
                  "p1=%b t1=%0d p2=%b t2=%0d cnt=%0d ; want ",
                  "st=%b p1=%b t1=%0d p2=%b t2=%0d cnt=%0d"},
                 e.name, out_stall, out_pc_write_disable,
                 out_IFID_write_disable, out_control_src,
                 out_rs1_pending, out_rs1_tag, out_rs2_pending,
                 out_rs2_tag, out_busy_count, e.st, e.p1, e.t1,
                 e.p2, e.t2, e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle();
    step();
    issue(6, 1, 0); rs1(5); rs2(9);
    expect_("reset", 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    idle(); step();

    // Load-use stall and same-cycle release
    idle(); issue(5, 3, 1);
    expect_("issue_x5", 0, 0, 0, 0, 0, 0); step();
    idle(); issue(6, 0, 0); rs1(5);
    expect_("raw_stall", 1, 1, 3, 0, 0, 1); step();
    idle(); issue(6, 0, 0); rs1(5); wb(1, 5, 3);
    expect_("wb_bypass", 0, 0, 0, 0, 0, 1); step();
    idle(); rs1(5);
    expect_("after_wb", 0, 0, 0, 0, 0, 0); step();

    // WAW: newest writer wins, stale completion ignored
    idle(); issue(5, 3, 1);
    expect_("waw_a", 0, 0, 0, 0, 0, 0); step();
    idle(); issue(5, 7, 1);
    expect_("waw_b", 0, 0, 0, 0, 0, 1); step();
    idle(); rs1(5); wb(0, 5, 3);
    expect_("stale_wb", 0, 1, 7, 0, 0, 1); step();
    idle(); rs1(5);
    expect_("stays_busy", 0, 1, 7, 0, 0, 1); step();
    idle(); rs2(5); wb(0, 5, 7);
    expect_("match_wb", 0, 0, 0, 0, 0, 1); step();
    idle(); rs2(5);
    expect_("waw_clear", 0, 0, 0, 0, 0, 0); step();

    // Issue beats completion on the same register
    idle(); issue(2, 1, 1);
    expect_("set_x2", 0, 0, 0, 0, 0, 0); step();
    idle(); issue(9, 4, 1);
    expect_("set_x9", 0, 0, 0, 0, 0, 1); step();
    idle(); issue(2, 5, 1); wb(0, 2, 1); wb(1, 9, 4);
    expect_("iss_vs_wb", 0, 0, 0, 0, 0, 2); step();
    idle(); rs1(2); rs2(9);
    expect_("iss_wins", 0, 1, 5, 0, 0, 1); step();
    idle(); wb(1, 2, 5);
    expect_("drain_x2", 0, 0, 0, 0, 0, 1); step();

    // Capacity limit
    for (int r = 1; r <= 8; r++) begin
      idle(); issue(r, r, 1);
      expect_("fill", 0, 0, 0, 0, 0, r - 1); step();
    end
    idle(); issue(10, 9, 1);
    expect_("full_new_rd", 1, 0, 0, 0, 0, 8); step();
    idle(); issue(3, 12, 1);
    expect_("full_busy_rd", 0, 0, 0, 0, 0, 8); step();
    idle(); rs1(3); rs2(10);
    expect_("full_retag", 0, 1, 12, 0, 0, 8); step();

    // Flush overrides issue; stall masked in flush cycle
    idle(); wb(0, 1, 1); wb(1, 2, 2);
    expect_("drop_two", 0, 0, 0, 0, 0, 8); step();
    idle(); issue(4, 5, 1); rs1(3); in_flush = 1'b1;
    expect_("flush_cyc", 0, 1, 12, 0, 0, 6); step();
    idle(); rs1(4); rs2(3);
    expect_("post_flush", 0, 0, 0, 0, 0, 0); step();

    // Asynchronous reset mid-operation
    idle(); issue(7, 2, 1);
    expect_("pre_rst_a", 0, 0, 0, 0, 0, 0); step();
    idle(); issue(8, 3, 1);
    expect_("pre_rst_b", 0, 0, 0, 0, 0, 1); step();
    idle(); rs1(7); rs2(8);
    expect_("pre_rst_c", 0, 1, 2, 1, 3, 2); step();
    idle(); issue(6, 0, 0); rs1(7); rs2(8);
    reset = 1'b0;
    expect_("async_rst", 0, 0, 0, 0, 0, 0); step();
    reset = 1'b1;

    // x0 is never tracked
    idle(); issue(0, 6, 1); rs1(0); rs2(0);
    expect_("x0_issue", 0, 0, 0, 0, 0, 0); step();
    idle(); rs1(0);
    expect_("x0_src", 0, 0, 0, 0, 0, 0); step();
    idle();

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Parametrised successor to the decode-stage load-use hazard check.
- Tracks every in-flight long-latency producer (loads, multi-cycle ALU ops) per architectural register, tagged with its ROB index.
- Stalls decode on a RAW dependency until a matching completion arrives. Accepts NUM_WB completion ports per cycle and clears everything on flush.
- Sits beside the register file in decode. Drives PC/IF-ID write-disable and the control-bubble select.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hard-wired zero.
- REG_W, 5, register index width, equal to clog2(NUM_REGS).
- ROB_IDX_W, 4, ROB tag width.
- NUM_WB, 2, completion ports per cycle.
- MAX_INFLIGHT, 8, maximum simultaneously busy registers; issue stalls when this is reached.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_issue_valid  in  1  decode holds a valid instruction.
- in_issue_long_lat  in  1  the instruction's result is not forwardable in EX (load or multi-cycle op).
- in_issue_rd  in  REG_W  destination register.
- in_issue_rob_idx  in  ROB_IDX_W  ROB tag allocated to this instruction.
- in_rs1, in_rs2  in  REG_W  source registers.
- in_rs1_used, in_rs2_used  in  1  the instruction actually reads that source.
- in_wb_valid  in  NUM_WB  completion valid, one bit per port.
- in_wb_rd  in  NUM_WB*REG_W  completing destination, packed by port.
- in_wb_rob_idx  in  NUM_WB*ROB_IDX_W  completing tag, packed by port.
- in_flush  in  1  pipeline flush (taken branch or exception).
- out_stall  out  1  hold decode and insert a bubble.
- out_pc_write_disable  out  1  equals out_stall.
- out_IFID_write_disable  out  1  equals out_stall.
- out_control_src  out  1  equals the inverse of out_stall (0 selects the zeroed control bundle).
- out_rs1_pending, out_rs2_pending  out  1  the source is still waiting on a producer.
- out_rs1_tag, out_rs2_tag  out  ROB_IDX_W  tag of the pending producer.
- out_busy_count  out  clog2(NUM_REGS+1)  number of busy registers.

Behaviour:
- State per register: busy bit and tag. Reset (reset=0, asynchronous) clears all busy bits, all tags and the count.
- Reset values of outputs: out_stall=0, write-disables=0, out_control_src=1, pending=0, tags=0, out_busy_count=0.
- Register 0 is never busy. Issue with rd=0 is ignored. A source of 0 is never pending.
- Lookup is combinational, zero-cycle.
  - rsN_pending = rsN_used AND busy[rsN], unless some port w in the same cycle has in_wb_valid[w], wb_rd[w]=rsN and wb_rob_idx[w]=tag[rsN]. The completion bypasses, and forwarding supplies the value.
  - rsN_tag = tag[rsN] when pending, else 0.
- out_stall = in_issue_valid AND NOT in_flush AND (rs1_pending OR rs2_pending OR (in_issue_long_lat AND rd≠0 AND count==MAX_INFLIGHT AND NOT busy[rd])).
- Issue fires when in_issue_valid, in_issue_long_lat, rd≠0, NOT out_stall and NOT in_flush.
  - On the next edge: busy[rd]=1 and tag[rd]=in_issue_rob_idx.
  - Re-issue to an already busy rd overwrites the tag (WAW: the newest writer wins) and does not change the count.
- Completion, per port: clears busy[rd] on the next edge only if busy[rd]=1 and tag matches. A stale tag is ignored.
  - Two ports naming the same register: only a tag match clears it; clearing is idempotent.
- Issue and completion to the same register in the same cycle: issue wins, so the register stays busy with the new tag.
- Flush: on the next edge all busy bits are cleared and the count goes to 0. Flush overrides issue and completion in that cycle and forces out_stall=0 that cycle.
- out_busy_count is registered. It equals the popcount of busy after each edge and never exceeds MAX_INFLIGHT.
- Latency: a dependent instruction sees pending the cycle after its producer issues and is released the cycle the matching completion is presented.

Decomposition:
- Shared package holds:
  - Parameter defaults.
  - Typedef for the per-register entry {busy, tag}.
  - Function to unpack the completion port vectors.
- One natural sub-module, scoreboard_lookup: a combinational read port with completion bypass, instantiated twice (rs1, rs2).

Test Plan:
- Load issues x5 with tag 3, next instruction uses rs1=x5 -> out_stall=1, rs1_tag=3, IF/ID and PC write-disabled, control_src=0. Completion (x5, tag 3) on port 1 -> stall=0 in that same cycle.
- x5 is issued with tag 3, then x5 is re-issued with tag 7, then completion (x5, tag 3) arrives -> x5 stays busy with tag 7 and the count is unchanged. Completion (x5, tag 7) -> x5 clear, count decremented.
- Both ports complete x2 (tag 1) and x9 (tag 4) while issue targets x2 with tag 5 in the same cycle -> x2 busy with tag 5, x9 clear.
- MAX_INFLIGHT=8 registers busy, a long-latency issue targets a new rd -> stall. The same issue targeting an already busy rd -> no stall, tag updated.
- Six registers busy, then flush together with an issue of x4 -> next cycle count=0 and x4 not busy. Reset asserted mid-operation -> busy state cleared immediately, without waiting for a clock edge.
- rd=0 issue and a source read of x0 -> never busy, never pending, count stays 0.
